// File: rtl/ds2_c64_joy_mapper.sv
// DualShock2 to C64 control-port mapper: synchronises pad inputs, snapshots them per frame,
// applies stick hysteresis, D-pad merge, fire/autofire, and drives active-low joystick plus pots.
module ds2_c64_joy_mapper #(
  parameter logic [7:0] ON_THR  = 8'd64,
  parameter logic [7:0] OFF_THR = 8'd48,
  parameter logic [3:0] AF_HALF = 4'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_cross,
  input  logic       key_square,
  input  logic       key_select,
  input  logic [7:0] stick_lx,
  input  logic [7:0] stick_ly,
  input  logic [7:0] stick_rx,
  input  logic [7:0] stick_ry,
  output logic [4:0] joy_n,
  output logic [7:0] pot_x,
  output logic [7:0] pot_y,
  output logic       autofire_en
);

  typedef enum logic [1:0] {
    AX_CENTER = 2'd0,
    AX_POS    = 2'd1,
    AX_NEG    = 2'd2
  } axis_t;

  localparam int unsigned K_UP  = 0;
  localparam int unsigned K_DN  = 1;
  localparam int unsigned K_LT  = 2;
  localparam int unsigned K_RT  = 3;
  localparam int unsigned K_CR  = 4;
  localparam int unsigned K_SQ  = 5;
  localparam int unsigned K_SEL = 6;

  // Raw bundle: {vsync, keys[6:0], lx, ly, rx, ry}
  logic [39:0] raw;
  logic [39:0] sync1_q, sync1_d;
  logic [39:0] sync2_q, sync2_d;
  logic        vs_prev_q, vs_prev_d;
  logic        snap_pulse;

  logic [6:0]  snap_keys_q, snap_keys_d;
  logic [7:0]  snap_lx_q, snap_lx_d;
  logic [7:0]  snap_ly_q, snap_ly_d;
  logic [7:0]  snap_rx_q, snap_rx_d;
  logic [7:0]  snap_ry_q, snap_ry_d;
  logic        eval_q, eval_d;
  logic        upd_q, upd_d;

  axis_t       x_state_q, x_state_d;
  axis_t       y_state_q, y_state_d;
  logic        sel_prev_q, sel_prev_d;
  logic        sq_prev_q, sq_prev_d;
  logic [3:0]  af_cnt_q, af_cnt_d;
  logic        af_phase_q, af_phase_d;
  logic        af_en_q, af_en_d;

  logic [4:0]  joy_n_q, joy_n_d;
  logic [7:0]  pot_x_q, pot_x_d;
  logic [7:0]  pot_y_q, pot_y_d;

  logic        frame_valid;
  logic [6:0]  keys_eff;
  logic        up, down, left, right, fire;

  assign raw = {vsync, key_select, key_square, key_cross, key_right, key_left,
                key_down, key_up, stick_lx, stick_ly, stick_rx, stick_ry};

  function automatic axis_t next_axis(input axis_t cur, input logic [7:0] v);
    logic signed [8:0] d;
    logic signed [8:0] on_p;
    logic signed [8:0] off_p;
    axis_t             nxt;
    d     = $signed({1'b0, v}) - 9'sd128;
    on_p  = $signed({1'b0, ON_THR});
    off_p = $signed({1'b0, OFF_THR});
    nxt   = cur;
    case (cur)
      AX_CENTER: begin
        if (d >= on_p)       nxt = AX_POS;
        else if (d <= -on_p) nxt = AX_NEG;
      end
      AX_POS: begin
        if (d <= -on_p)      nxt = AX_NEG;
        else if (d < off_p)  nxt = AX_CENTER;
      end
      AX_NEG: begin
        if (d >= on_p)       nxt = AX_POS;
        else if (d > -off_p) nxt = AX_CENTER;
      end
      default:               nxt = AX_CENTER;
    endcase
    return nxt;
  endfunction

  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    vs_prev_d  = sync2_q[39];
    snap_pulse = sync2_q[39] & ~vs_prev_q;
    eval_d     = snap_pulse;
    upd_d      = eval_q;

    snap_keys_d = snap_keys_q;
    snap_lx_d   = snap_lx_q;
    snap_ly_d   = snap_ly_q;
    snap_rx_d   = snap_rx_q;
    snap_ry_d   = snap_ry_q;
    if (snap_pulse) begin
      snap_keys_d = sync2_q[38:32];
      snap_lx_d   = sync2_q[31:24];
      snap_ly_d   = sync2_q[23:16];
      snap_rx_d   = sync2_q[15:8];
      snap_ry_d   = sync2_q[7:0];
    end
  end

  // A frame with all four stick bytes at zero means no controller answered the poll.
  assign frame_valid = |{snap_lx_q, snap_ly_q, snap_rx_q, snap_ry_q};
  assign keys_eff    = frame_valid ? snap_keys_q : '0;

  always_comb begin
    x_state_d  = x_state_q;
    y_state_d  = y_state_q;
    sel_prev_d = sel_prev_q;
    sq_prev_d  = sq_prev_q;
    af_cnt_d   = af_cnt_q;
    af_phase_d = af_phase_q;
    af_en_d    = af_en_q;
    if (eval_q) begin
      x_state_d  = frame_valid ? next_axis(x_state_q, snap_lx_q) : AX_CENTER;
      y_state_d  = frame_valid ? next_axis(y_state_q, snap_ly_q) : AX_CENTER;
      sel_prev_d = keys_eff[K_SEL];
      sq_prev_d  = keys_eff[K_SQ];
      if (keys_eff[K_SEL] && !sel_prev_q) af_en_d = ~af_en_q;
      if (keys_eff[K_SQ] && !sq_prev_q) begin
        af_cnt_d   = '0;
        af_phase_d = 1'b1;
      end else if (af_cnt_q >= AF_HALF - 4'd1) begin
        af_cnt_d   = '0;
        af_phase_d = ~af_phase_q;
      end else begin
        af_cnt_d   = af_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    up    = keys_eff[K_UP] | (y_state_q == AX_NEG);
    down  = keys_eff[K_DN] | (y_state_q == AX_POS);
    left  = keys_eff[K_LT] | (x_state_q == AX_NEG);
    right = keys_eff[K_RT] | (x_state_q == AX_POS);
    fire  = keys_eff[K_CR] | (keys_eff[K_SQ] & (af_en_q ? af_phase_q : 1'b1));

    joy_n_d = joy_n_q;
    pot_x_d = pot_x_q;
    pot_y_d = pot_y_q;
    if (upd_q) begin
      joy_n_d = ~{fire, right & ~left, left & ~right, down & ~up, up & ~down};
      pot_x_d = frame_valid ? snap_rx_q : 8'h80;
      pot_y_d = frame_valid ? snap_ry_q : 8'h80;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      vs_prev_q   <= 1'b0;
      eval_q      <= 1'b0;
      upd_q       <= 1'b0;
      snap_keys_q <= '0;
      snap_lx_q   <= 8'h80;
      snap_ly_q   <= 8'h80;
      snap_rx_q   <= 8'h80;
      snap_ry_q   <= 8'h80;
      x_state_q   <= AX_CENTER;
      y_state_q   <= AX_CENTER;
      sel_prev_q  <= 1'b0;
      sq_prev_q   <= 1'b0;
      af_cnt_q    <= '0;
      af_phase_q  <= 1'b0;
      af_en_q     <= 1'b0;
      joy_n_q     <= '1;
      pot_x_q     <= 8'h80;
      pot_y_q     <= 8'h80;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      vs_prev_q   <= vs_prev_d;
      eval_q      <= eval_d;
      upd_q       <= upd_d;
      snap_keys_q <= snap_keys_d;
      snap_lx_q   <= snap_lx_d;
      snap_ly_q   <= snap_ly_d;
      snap_rx_q   <= snap_rx_d;
      snap_ry_q   <= snap_ry_d;
      x_state_q   <= x_state_d;
      y_state_q   <= y_state_d;
      sel_prev_q  <= sel_prev_d;
      sq_prev_q   <= sq_prev_d;
      af_cnt_q    <= af_cnt_d;
      af_phase_q  <= af_phase_d;
      af_en_q     <= af_en_d;
      joy_n_q     <= joy_n_d;
      pot_x_q     <= pot_x_d;
      pot_y_q     <= pot_y_d;
    end
  end

  assign joy_n       = joy_n_q;
  assign pot_x       = pot_x_q;
  assign pot_y       = pot_y_q;
  assign autofire_en = af_en_q;

endmodule

// File: tb/tb_ds2_c64_joy_mapper.sv
// Directed scoreboard bench for ds2_c64_joy_mapper: each frame pushes its expected outputs,
// which are popped and checked once the frame's result has settled.
module tb_ds2_c64_joy_mapper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       key_up, key_down, key_left, key_right;
  logic       key_cross, key_square, key_select;
  logic [7:0] stick_lx, stick_ly, stick_rx, stick_ry;
  logic [4:0] joy_n;
  logic [7:0] pot_x, pot_y;
  logic       autofire_en;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [4:0] joy;
    logic [7:0] px;
    logic [7:0] py;
    logic       af;
  } exp_t;

  exp_t sb[$];

  ds2_c64_joy_mapper #(.ON_THR(8'd64), .OFF_THR(8'd48), .AF_HALF(4'd3)) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .key_cross(key_cross), .key_square(key_square), .key_select(key_select),
    .stick_lx(stick_lx), .stick_ly(stick_ly), .stick_rx(stick_rx), .stick_ry(stick_ry),
    .joy_n(joy_n), .pot_x(pot_x), .pot_y(pot_y), .autofire_en(autofire_en)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // keys packed as {select, square, cross, right, left, down, up}
  task automatic setin(input logic [6:0] k, input logic [7:0] lx, input logic [7:0] ly,
                       input logic [7:0] rx, input logic [7:0] ry);
    {key_select, key_square, key_cross, key_right, key_left, key_down, key_up} = k;
    stick_lx = lx; stick_ly = ly; stick_rx = rx; stick_ry = ry;
  endtask

  task automatic frame(input string tag, input logic [4:0] ej, input logic [7:0] epx,
                       input logic [7:0] epy, input logic eaf);
    exp_t e;
    e.tag = tag; e.joy = ej; e.px = epx; e.py = epy; e.af = eaf;
    sb.push_back(e);
    repeat (4) @(posedge clk);
    #1 vsync = 1'b1;
    @(posedge clk);
    #1 vsync = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".joy"}, {3'b000, joy_n}, {3'b000, e.joy});
    chk({e.tag, ".potx"}, pot_x, e.px);
    chk({e.tag, ".poty"}, pot_y, e.py);
    chk({e.tag, ".af"}, {7'd0, autofire_en}, {7'd0, e.af});
  endtask

  initial begin
    logic [9:0] af_pat;
    af_pat = 10'b1110001110;
    rst_n = 1'b0;
    vsync = 1'b0;
    setin(7'd0, 8'h80, 8'h80, 8'h80, 8'h80);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.joy", {3'b000, joy_n}, 8'h1F);
    chk("rst.potx", pot_x, 8'h80);
    chk("rst.poty", pot_y, 8'h80);
    chk("rst.af", {7'd0, autofire_en}, 8'h00);
    rst_n = 1'b1;

    frame("neutral", 5'h1F, 8'h80, 8'h80, 1'b0);
    setin(7'd0, 8'hBF, 8'h80, 8'h80, 8'h80); frame("x_d63", 5'h1F, 8'h80, 8'h80, 1'b0);
    setin(7'd0, 8'hC0, 8'h80, 8'h80, 8'h80); frame("x_on", 5'h17, 8'h80, 8'h80, 1'b0);
    setin(7'd0, 8'hB0, 8'h80, 8'h80, 8'h80); frame("x_hold", 5'h17, 8'h80, 8'h80, 1'b0);
    setin(7'd0, 8'hAF, 8'h80, 8'h80, 8'h80); frame("x_off", 5'h1F, 8'h80, 8'h80, 1'b0);
    setin(7'd0, 8'h3F, 8'h80, 8'h80, 8'h80); frame("x_neg", 5'h1B, 8'h80, 8'h80, 1'b0);
    setin(7'd0, 8'hC0, 8'h80, 8'h80, 8'h80); frame("neg2pos", 5'h17, 8'h80, 8'h80, 1'b0);
    setin(7'd0, 8'h40, 8'h80, 8'h80, 8'h80); frame("pos2neg", 5'h1B, 8'h80, 8'h80, 1'b0);
    setin(7'd0, 8'h80, 8'h80, 8'h80, 8'h80); frame("x_ctr", 5'h1F, 8'h80, 8'h80, 1'b0);

    setin(7'b0000001, 8'h80, 8'hFF, 8'h80, 8'h80); frame("ud_cancel", 5'h1F, 8'h80, 8'h80, 1'b0);
    setin(7'b0000010, 8'h80, 8'h80, 8'h12, 8'hEE); frame("down", 5'h1D, 8'h12, 8'hEE, 1'b0);
    setin(7'b0000100, 8'hC0, 8'h80, 8'h80, 8'h80); frame("lr_cancel", 5'h1F, 8'h80, 8'h80, 1'b0);
    setin(7'd0, 8'h80, 8'h80, 8'h80, 8'h80); frame("idle", 5'h1F, 8'h80, 8'h80, 1'b0);

    for (int unsigned i = 0; i < 3; i++) begin
      setin(7'b1000000, 8'h80, 8'h80, 8'h80, 8'h80);
      frame($sformatf("sel%0d", i), 5'h1F, 8'h80, 8'h80, 1'b1);
    end
    setin(7'd0, 8'h80, 8'h80, 8'h80, 8'h80); frame("sel_rel", 5'h1F, 8'h80, 8'h80, 1'b1);

    for (int unsigned i = 0; i < 10; i++) begin
      setin(7'b0100000, 8'h80, 8'h80, 8'h80, 8'h80);
      frame($sformatf("af%0d", i), af_pat[9-i] ? 5'h0F : 5'h1F, 8'h80, 8'h80, 1'b1);
    end
    for (int unsigned i = 0; i < 3; i++) begin
      setin(7'b0110000, 8'h80, 8'h80, 8'h80, 8'h80);
      frame($sformatf("cross%0d", i), 5'h0F, 8'h80, 8'h80, 1'b1);
    end
    setin(7'd0, 8'h80, 8'h80, 8'h80, 8'h80); frame("rel", 5'h1F, 8'h80, 8'h80, 1'b1);

    setin(7'b1001000, 8'h00, 8'h00, 8'h00, 8'h00); frame("invalid", 5'h1F, 8'h80, 8'h80, 1'b1);
    setin(7'b1000000, 8'h80, 8'h80, 8'h80, 8'h80); frame("sel_after_inv", 5'h1F, 8'h80, 8'h80, 1'b0);
    setin(7'd0, 8'h80, 8'h80, 8'h80, 8'h80); frame("sel_rel2", 5'h1F, 8'h80, 8'h80, 1'b0);
    setin(7'b1000000, 8'h80, 8'h80, 8'h80, 8'h80); frame("sel_on2", 5'h1F, 8'h80, 8'h80, 1'b1);
    setin(7'd0, 8'h80, 8'h80, 8'h80, 8'h80); frame("sel_rel3", 5'h1F, 8'h80, 8'h80, 1'b1);

    // vsync held high: the change during the high phase must not be sampled
    repeat (4) @(posedge clk);
    #1 vsync = 1'b1;
    repeat (8) @(posedge clk);
    #1 stick_lx = 8'hC0;
    repeat (10) @(posedge clk);
    #1;
    chk("vs_held.joy", {3'b000, joy_n}, 8'h1F);
    vsync = 1'b0;
    frame("vs_next", 5'h17, 8'h80, 8'h80, 1'b1);
    setin(7'd0, 8'h80, 8'h80, 8'h80, 8'h80); frame("vs_ctr", 5'h1F, 8'h80, 8'h80, 1'b1);

    // reset lands after the snapshot but before the output register
    setin(7'd0, 8'hC0, 8'h80, 8'h80, 8'h80);
    repeat (4) @(posedge clk);
    #1 vsync = 1'b1;
    @(posedge clk);
    #1 vsync = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid.joy", {3'b000, joy_n}, 8'h1F);
    chk("rst_mid.af", {7'd0, autofire_en}, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("no_stale.joy", {3'b000, joy_n}, 8'h1F);
    chk("no_stale.af", {7'd0, autofire_en}, 8'h00);
    chk("no_stale.potx", pot_x, 8'h80);
    frame("post_rst", 5'h17, 8'h80, 8'h80, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ds2_c64_joy_mapper.md
Name: ds2_c64_joy_mapper

Overview:
- Consumes decoded DualShock2 key and stick outputs and produces a C64 control-port joystick word (active-low) plus two paddle/pot values.
- Sits directly downstream of the DualShock2 interface and upstream of the CIA/SID port muxing.
- Synchronises the slow-domain inputs and snapshots them once per frame.
- Converts the left analog stick to digital directions with hysteresis, merges them with the D-pad, and generates fire and autofire.

Parameters:
- ON_THR, 8'd64: deflection from centre (128) at which an analog axis asserts a direction.
- OFF_THR, 8'd48: deflection below which an asserted axis returns to centre. Must be ≤ ON_THR.
- AF_HALF, 4'd3: autofire half-period in frames. Must be ≥ 1.

Ports:
- clk in 1: system clock, the only clock.
- rst_n in 1: reset, asynchronous assert, active-low.
- vsync in 1: frame sync, active high. Same signal that drives the DualShock2 poll.
- key_up, key_down, key_left, key_right in 1 each: D-pad, active high.
- key_cross, key_square, key_select in 1 each: fire, autofire-fire, autofire toggle.
- stick_lx, stick_ly in 8 each: left stick. 0x00 = left/up, 0xFF = right/down.
- stick_rx, stick_ry in 8 each: right stick, used for paddles.
- joy_n out 5: bit0 up, bit1 down, bit2 left, bit3 right, bit4 fire. Active-low.
- pot_x, pot_y out 8: paddle values.
- autofire_en out 1: autofire mode indicator.

Behaviour:
- Reset values: joy_n=5'b11111, pot_x=pot_y=8'h80, autofire_en=0. Both axis FSMs in CENTER, autofire counter=0, phase=0, snapshot regs cleared (sticks 8'h80, keys 0).
- Synchronisation: every input bit passes through a 2-FF synchroniser. vsync gets one extra register for edge detection.
- Snapshot: at cycle N, synced vsync=1 and previous=0. On that cycle all synced keys and sticks load into snapshot registers, which are held otherwise. Multi-bit stick values are only consumed from the snapshot.
- Absent controller: if the snapshot has lx=ly=rx=ry=8'h00, the frame is invalid:
  - both axes are forced to CENTER;
  - pots are driven 8'h80;
  - all keys are treated as released, including for select edge detection;
  - autofire_en is held.
- Axis FSM (X from lx, Y from ly), evaluated at cycle N+1. d = value − 128, signed 9-bit.
  - CENTER→POS if d ≥ ON_THR; CENTER→NEG if d ≤ −ON_THR.
  - POS→CENTER if d < OFF_THR; NEG→CENTER if d > −OFF_THR.
  - POS→NEG directly if d ≤ −ON_THR; NEG→POS directly if d ≥ ON_THR.
  - Otherwise hold.
- Direction merge:
  - up = key_up | Y==NEG; down = key_down | Y==POS; left = key_left | X==NEG; right = key_right | X==POS.
  - If up and down are both true, both are deasserted; left/right likewise.
- Autofire toggle: a rising edge of snapshot key_select (previous frame 0, this frame 1) toggles autofire_en at N+1. Holding select does not retoggle.
- Autofire generator, advances once per snapshot:
  - counter runs 0..AF_HALF−1; at wrap, phase toggles.
  - When key_square goes 0→1, counter←0 and phase←1, so fire is asserted in the first frame.
  - With AF_HALF=1, phase toggles every frame.
- Fire = key_cross | (key_square & (autofire_en ? phase : 1)). With autofire off, square is plain fire.
- Outputs: joy_n and pots register at N+2, i.e. latency 2 clk from the snapshot cycle. All bits come from the same frame and are stable between snapshots.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). The first valid update follows the first vsync rising edge after rst_n deasserts plus the synchroniser delay.
- vsync high for only 1 clk still produces exactly one snapshot. vsync held high produces one snapshot per rising edge.

Test Plan:
- Reset, then one frame with lx=ly=8'h80 and no keys → joy_n=5'b11111, pot_x=pot_y=8'h80, 2 clk after the snapshot cycle.
- Hysteresis: lx sequence per frame 0xC0, 0xB0, 0xAF, 0x3F → right asserted (d=64), held (d=48), released (d=47), then left asserted; joy_n bit3 then bit2 go low.
- key_up=1 with ly=0xFF (Y POS) → up and down both cancelled, joy_n[1:0]=2'b11. key_down alone → joy_n[1]=0.
- Select pressed for 3 frames → autofire_en toggles once to 1. Then square held 10 frames with AF_HALF=3 → fire pattern per frame 1,1,1,0,0,0,1,1,1,0. Cross held overrides to constant fire.
- All sticks 8'h00 with key_right=1 → frame invalid, joy_n=5'b11111, pots 8'h80.
- Assert rst_n low between snapshot and output cycle → joy_n=5'b11111 immediately, autofire_en=0, no stale update after release.
